pipe_ctrl_unit: RTL and testbench

Second-generation control unit for the 5-stage RV32I pipeline. It decodes the ID-stage instruction into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB stage registers. It also produces load-use stall, branch/jump flush and EX-stage forwarding selects. It sits between the IF/ID register and the datapath, replacing the purely combinational opcode decoder.

---
 rtl/pipe_ctrl_unit.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// RV32I 5-stage pipeline control: ID decode, ID/EX-EX/MEM-MEM/WB control registers, hazard and forwarding.
// Optional multi-cycle M-extension sequencing is enabled by defining CTRL_MULDIV_EN.
module pipe_ctrl_unit #(
  parameter int RA_W    = 5,
  parameter int MUL_LAT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     id_instr,
  input  logic            id_valid,
  input  logic            ex_branch_taken,
  output logic            pc_stall,
  output logic            ifid_stall,
  output logic            ifid_flush,
  output logic            ex_alusrc,
  output logic            ex_memtoreg,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_branch,
  output logic            ex_jal,
  output logic            ex_jalr,
  output logic            ex_illegal,
  output logic [1:0]      ex_aluop,
  output logic [RA_W-1:0] ex_rd,
  output logic [RA_W-1:0] ex_rs1,
  output logic [RA_W-1:0] ex_rs2,
  output logic            mem_regwrite,
  output logic            mem_memtoreg,
  output logic            mem_memread,
  output logic            mem_memwrite,
  output logic [RA_W-1:0] mem_rd,
  output logic            wb_regwrite,
  output logic            wb_memtoreg,
  output logic [RA_W-1:0] wb_rd,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b
`ifdef CTRL_MULDIV_EN
  ,
  output logic            ex_m
`endif
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [RA_W-1:0] REG_X0 = {RA_W{1'b0}};

  logic [6:0]      id_opcode_s;
  logic [RA_W-1:0] id_rd_s;
  logic [RA_W-1:0] id_rs1_s;
  logic [RA_W-1:0] id_rs2_s;

  logic       dec_alusrc_s;
  logic       dec_memtoreg_s;
  logic       dec_regwrite_s;
  logic       dec_memread_s;
  logic       dec_memwrite_s;
  logic       dec_branch_s;
  logic       dec_jal_s;
  logic       dec_jalr_s;
  logic       dec_illegal_s;
  logic       dec_m_s;
  logic [1:0] dec_aluop_s;
  logic       rs2_used_s;

  logic busy_s;
  logic load_use_s;
  logic flush_s;
  logic bubble_s;

  assign id_opcode_s = id_instr[6:0];
  assign id_rd_s     = id_instr[7 +: RA_W];
  assign id_rs1_s    = id_instr[15 +: RA_W];
  assign id_rs2_s    = id_instr[20 +: RA_W];

  // Opcode decode of the ID-stage instruction into a control bundle
  always_comb begin
    dec_alusrc_s   = 1'b0;
    dec_memtoreg_s = 1'b0;
    dec_regwrite_s = 1'b0;
    dec_memread_s  = 1'b0;
    dec_memwrite_s = 1'b0;
    dec_branch_s   = 1'b0;
    dec_jal_s      = 1'b0;
    dec_jalr_s     = 1'b0;
    dec_illegal_s  = 1'b0;
    dec_m_s        = 1'b0;
    dec_aluop_s    = 2'b00;
    rs2_used_s     = 1'b0;
    case (id_opcode_s)
      OP_R: begin
        dec_regwrite_s = 1'b1;
        dec_aluop_s    = 2'b10;
        rs2_used_s     = 1'b1;
`ifdef CTRL_MULDIV_EN
        dec_m_s        = (id_instr[31:25] == 7'b0000001);
`endif
      end
      OP_I: begin
        dec_alusrc_s   = 1'b1;
        dec_regwrite_s = 1'b1;
        dec_aluop_s    = 2'b10;
      end
      OP_LW: begin
        dec_alusrc_s   = 1'b1;
        dec_memtoreg_s = 1'b1;
        dec_regwrite_s = 1'b1;
        dec_memread_s  = 1'b1;
      end
      OP_SW: begin
        dec_alusrc_s   = 1'b1;
        dec_memwrite_s = 1'b1;
        rs2_used_s     = 1'b1;
      end
      OP_BR: begin
        dec_branch_s   = 1'b1;
        dec_aluop_s    = 2'b01;
        rs2_used_s     = 1'b1;
      end
      OP_LUI: begin
        dec_alusrc_s   = 1'b1;
        dec_regwrite_s = 1'b1;
        dec_aluop_s    = 2'b11;
      end
      OP_JAL: begin
        dec_regwrite_s = 1'b1;
        dec_jal_s      = 1'b1;
      end
      OP_JALR: begin
        dec_alusrc_s   = 1'b1;
        dec_regwrite_s = 1'b1;
        dec_jal_s      = 1'b1;
        dec_jalr_s     = 1'b1;
        dec_aluop_s    = 2'b11;
      end
      OP_AUIPC: begin
        dec_alusrc_s   = 1'b1;
        dec_regwrite_s = 1'b1;
      end
      default: begin
        dec_illegal_s  = 1'b1;
      end
    endcase
  end

`ifdef CTRL_MULDIV_EN
  localparam int CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  logic             state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             m_enter_s;

  assign busy_s    = (state_r == ST_BUSY);
  assign m_enter_s = dec_m_s & ~bubble_s & ~busy_s;

  // Busy sequencer: holds EX for MUL_LAT cycles once an M-op lands there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (m_enter_s) begin
            state_r <= ST_BUSY;
            cnt_r   <= CNT_W'(MUL_LAT - 2);
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end
`else
  logic unused_bits_s;
  assign unused_bits_s = ^{id_instr[31:25], dec_m_s};
  assign busy_s        = 1'b0;
`endif

  logic unused_f3_s;
  assign unused_f3_s = ^id_instr[14:12];

  // Hazard detection; flush outranks load-use, neither is acted on while busy
  always_comb begin
    load_use_s = id_valid & ex_memread & (ex_rd != REG_X0) & ~busy_s &
                 ((ex_rd == id_rs1_s) | (rs2_used_s & (ex_rd == id_rs2_s)));
    flush_s    = ex_branch_taken & ~busy_s & rst_n;
    bubble_s   = flush_s | load_use_s | ~id_valid;
  end

  assign pc_stall   = busy_s | (load_use_s & ~flush_s);
  assign ifid_stall = busy_s | (load_use_s & ~flush_s);
  assign ifid_flush = flush_s;

  // ID/EX register: hold while busy, bubble on hazard/flush/invalid, else capture decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_alusrc   <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_branch   <= 1'b0;
      ex_jal      <= 1'b0;
      ex_jalr     <= 1'b0;
      ex_illegal  <= 1'b0;
      ex_aluop    <= 2'b00;
      ex_rd       <= REG_X0;
      ex_rs1      <= REG_X0;
      ex_rs2      <= REG_X0;
`ifdef CTRL_MULDIV_EN
      ex_m        <= 1'b0;
`endif
    end else if (busy_s) begin
      ex_aluop    <= ex_aluop;
    end else if (bubble_s) begin
      ex_alusrc   <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_branch   <= 1'b0;
      ex_jal      <= 1'b0;
      ex_jalr     <= 1'b0;
      ex_illegal  <= 1'b0;
      ex_aluop    <= 2'b00;
      ex_rd       <= REG_X0;
      ex_rs1      <= REG_X0;
      ex_rs2      <= REG_X0;
`ifdef CTRL_MULDIV_EN
      ex_m        <= 1'b0;
`endif
    end else begin
      ex_alusrc   <= dec_alusrc_s;
      ex_memtoreg <= dec_memtoreg_s;
      ex_regwrite <= dec_regwrite_s;
      ex_memread  <= dec_memread_s;
      ex_memwrite <= dec_memwrite_s;
      ex_branch   <= dec_branch_s;
      ex_jal      <= dec_jal_s;
      ex_jalr     <= dec_jalr_s;
      ex_illegal  <= dec_illegal_s;
      ex_aluop    <= dec_aluop_s;
      ex_rd       <= id_rd_s;
      ex_rs1      <= id_rs1_s;
      ex_rs2      <= id_rs2_s;
`ifdef CTRL_MULDIV_EN
      ex_m        <= dec_m_s;
`endif
    end
  end

  // EX/MEM register: a stalled multi-cycle op leaves bubbles behind it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_regwrite <= 1'b0;
      mem_memtoreg <= 1'b0;
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
      mem_rd       <= REG_X0;
    end else if (busy_s) begin
      mem_regwrite <= 1'b0;
      mem_memtoreg <= 1'b0;
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
      mem_rd       <= REG_X0;
    end else begin
      mem_regwrite <= ex_regwrite;
      mem_memtoreg <= ex_memtoreg;
      mem_memread  <= ex_memread;
      mem_memwrite <= ex_memwrite;
      mem_rd       <= ex_rd;
    end
  end

  // MEM/WB register, never stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_regwrite <= 1'b0;
      wb_memtoreg <= 1'b0;
      wb_rd       <= REG_X0;
    end else begin
      wb_regwrite <= mem_regwrite;
      wb_memtoreg <= mem_memtoreg;
      wb_rd       <= mem_rd;
    end
  end

  // EX operand forwarding selects; the younger MEM result wins over WB
  always_comb begin
    if (mem_regwrite && (mem_rd != REG_X0) && (mem_rd == ex_rs1)) begin
      fwd_a = 2'b10;
    end else if (wb_regwrite && (wb_rd != REG_X0) && (wb_rd == ex_rs1)) begin
      fwd_a = 2'b01;
    end else begin
      fwd_a = 2'b00;
    end
    if (mem_regwrite && (mem_rd != REG_X0) && (mem_rd == ex_rs2)) begin
      fwd_b = 2'b10;
    end else if (wb_regwrite && (wb_rd != REG_X0) && (wb_rd == ex_rs2)) begin
      fwd_b = 2'b01;
    end else begin
      fwd_b = 2'b00;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed scenarios plus a randomized stream
// checked against a stage-queue reference model. Honours CTRL_MULDIV_EN.
module tb_pipe_ctrl_unit;

  localparam int RA_W    = 5;
  localparam int MUL_LAT = 4;
`ifdef CTRL_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] id_instr = 32'h0;
  logic id_valid = 1'b0;
  logic ex_branch_taken = 1'b0;
  logic pc_stall, ifid_stall, ifid_flush;
  logic ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite;
  logic ex_branch, ex_jal, ex_jalr, ex_illegal;
  logic [1:0] ex_aluop;
  logic [RA_W-1:0] ex_rd, ex_rs1, ex_rs2;
  logic mem_regwrite, mem_memtoreg, mem_memread, mem_memwrite;
  logic [RA_W-1:0] mem_rd;
  logic wb_regwrite, wb_memtoreg;
  logic [RA_W-1:0] wb_rd;
  logic [1:0] fwd_a, fwd_b;
  logic ex_m_w;
`ifdef CTRL_MULDIV_EN
  logic ex_m;
  assign ex_m_w = ex_m;
`else
  assign ex_m_w = 1'b0;
`endif

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.RA_W(RA_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
    .ex_branch_taken(ex_branch_taken), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
    .ifid_flush(ifid_flush), .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_illegal(ex_illegal),
    .ex_aluop(ex_aluop), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .mem_rd(mem_rd), .wb_regwrite(wb_regwrite),
    .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd), .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef CTRL_MULDIV_EN
    , .ex_m(ex_m)
`endif
  );

  wire [49:0] obs_w = {pc_stall, ifid_stall, ifid_flush, ex_alusrc, ex_memtoreg, ex_regwrite,
                       ex_memread, ex_memwrite, ex_branch, ex_jal, ex_jalr, ex_illegal, ex_m_w,
                       ex_aluop, ex_rd, ex_rs1, ex_rs2, mem_regwrite, mem_memtoreg, mem_memread,
                       mem_memwrite, mem_rd, wb_regwrite, wb_memtoreg, wb_rd, fwd_a, fwd_b};

  typedef struct packed {
    logic alusrc, memtoreg, regwrite, memread, memwrite, branch, jal, jalr, illegal, m;
    logic [1:0] aluop;
    logic [4:0] rd, rs1, rs2;
  } ctl_t;

  // reference model: contents of the EX, MEM and WB slots plus remaining busy cycles
  ctl_t m_ex, m_mem, m_wb;
  int md_left;
  logic [49:0] obs, exp_v;
  logic exp_stall, exp_flush;
  int n_tests = 0;
  int n_fail = 0;

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [4:0] rd,
                                      input logic [6:0] op);
    return {f7, rs2, rs1, 3'b000, rd, op};
  endfunction

  function automatic ctl_t decode(input logic [31:0] ins);
    ctl_t c;
    c = '0;
    c.rd = ins[11:7];
    c.rs1 = ins[19:15];
    c.rs2 = ins[24:20];
    if (ins[6:0] == OP_R) begin
      c.regwrite = 1'b1; c.aluop = 2'b10; c.m = MD && (ins[31:25] == 7'b0000001);
    end else if (ins[6:0] == OP_I) begin
      c.alusrc = 1'b1; c.regwrite = 1'b1; c.aluop = 2'b10;
    end else if (ins[6:0] == OP_LW) begin
      c.alusrc = 1'b1; c.regwrite = 1'b1; c.memtoreg = 1'b1; c.memread = 1'b1;
    end else if (ins[6:0] == OP_SW) begin
      c.alusrc = 1'b1; c.memwrite = 1'b1;
    end else if (ins[6:0] == OP_BR) begin
      c.branch = 1'b1; c.aluop = 2'b01;
    end else if (ins[6:0] == OP_LUI) begin
      c.alusrc = 1'b1; c.regwrite = 1'b1; c.aluop = 2'b11;
    end else if (ins[6:0] == OP_JAL) begin
      c.regwrite = 1'b1; c.jal = 1'b1;
    end else if (ins[6:0] == OP_JALR) begin
      c.alusrc = 1'b1; c.regwrite = 1'b1; c.jal = 1'b1; c.jalr = 1'b1; c.aluop = 2'b11;
    end else if (ins[6:0] == OP_AUIPC) begin
      c.alusrc = 1'b1; c.regwrite = 1'b1;
    end else begin
      c.illegal = 1'b1;
    end
    return c;
  endfunction

  function automatic logic [1:0] fwd_of(input logic [4:0] rs);
    if (m_mem.regwrite && m_mem.rd != 5'd0 && m_mem.rd == rs) return 2'b10;
    if (m_wb.regwrite && m_wb.rd != 5'd0 && m_wb.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_ex = '0; m_mem = '0; m_wb = '0; md_left = 0;
    exp_stall = 1'b0; exp_flush = 1'b0;
  endtask

  // one ID cycle: drive, sample outputs, predict them, advance the model
  task automatic step(input logic [31:0] ins, input logic v, input logic bt);
    ctl_t d, e;
    logic busy, lu, fl, used;
    @(negedge clk);
    id_instr = ins; id_valid = v; ex_branch_taken = bt;
    #1;
    obs = obs_w;
    busy = (md_left > 0);
    d = decode(ins);
    used = (ins[6:0] == OP_R) || (ins[6:0] == OP_SW) || (ins[6:0] == OP_BR);
    lu = !busy && v && m_ex.memread && m_ex.rd != 5'd0 &&
         (m_ex.rd == ins[19:15] || (used && m_ex.rd == ins[24:20]));
    fl = !busy && bt;
    exp_stall = busy || (lu && !fl);
    exp_flush = fl;
    e = m_ex;
    exp_v = {exp_stall, exp_stall, exp_flush, e.alusrc, e.memtoreg, e.regwrite, e.memread,
             e.memwrite, e.branch, e.jal, e.jalr, e.illegal, e.m, e.aluop, e.rd, e.rs1, e.rs2,
             m_mem.regwrite, m_mem.memtoreg, m_mem.memread, m_mem.memwrite, m_mem.rd,
             m_wb.regwrite, m_wb.memtoreg, m_wb.rd, fwd_of(e.rs1), fwd_of(e.rs2)};
    m_wb = m_mem;
    m_mem = busy ? ctl_t'('0) : e;
    if (!busy) m_ex = (fl || lu || !v) ? ctl_t'('0) : d;
    if (busy) md_left = md_left - 1;
    else if (m_ex.m) md_left = MUL_LAT - 1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step(32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    #12;
    n_tests++;
    if (obs_w !== 50'b0) begin
      n_fail++; $display("FAIL reset_state got=%h want=0", obs_w);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_async_reset();
    step(enc(7'd0, 5'd2, 5'd1, 5'd3, OP_R), 1'b1, 1'b0);
    step(enc(7'd0, 5'd0, 5'd1, 5'd5, OP_LW), 1'b1, 1'b0);
    step(enc(7'd0, 5'd5, 5'd5, 5'd6, OP_R), 1'b1, 1'b0);
    #2;
    rst_n = 1'b0; ex_branch_taken = 1'b1;
    #1;
    n_tests++;
    if (obs_w !== 50'b0) begin
      n_fail++; $display("FAIL async_reset got=%h want=0", obs_w);
    end
    @(posedge clk); #1;
    n_tests++;
    if (obs_w !== 50'b0) begin
      n_fail++; $display("FAIL reset_hold got=%h want=0", obs_w);
    end
    @(negedge clk);
    rst_n = 1'b1; ex_branch_taken = 1'b0; id_valid = 1'b0;
    model_reset();
    step(enc(7'd0, 5'd2, 5'd1, 5'd6, OP_R), 1'b1, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    n_tests++;
    if (ex_regwrite !== 1'b1 || ex_aluop !== 2'b10 || obs !== exp_v) begin
      n_fail++; $display("FAIL first_add got=%h want=%h", obs, exp_v);
    end
  endtask

  task automatic test_load_use();
    int nstall;
    drain();
    nstall = 0;
    step(enc(7'd0, 5'd0, 5'd1, 5'd5, OP_LW), 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(enc(7'd0, 5'd7, 5'd5, 5'd6, OP_R), 1'b1, 1'b0);
      if (pc_stall === 1'b1 && ifid_stall === 1'b1) nstall++;
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL load_use_cyc%0d got=%h want=%h", i, obs, exp_v);
      end
    end
    n_tests++;
    if (nstall != 1 || ex_regwrite !== 1'b0 || ex_rd !== 5'd0) begin
      n_fail++; $display("FAIL load_use_stall stalls=%0d ex_rd=%0d want 1/0", nstall, ex_rd);
    end
    step(32'h0, 1'b0, 1'b0);
    n_tests++;
    if (ex_rd !== 5'd6 || fwd_a !== 2'b01 || obs !== exp_v) begin
      n_fail++; $display("FAIL load_use_fwd ex_rd=%0d fwd_a=%b want 6/01", ex_rd, fwd_a);
    end
  endtask

  task automatic test_forwarding();
    drain();
    step(enc(7'd0, 5'd2, 5'd1, 5'd3, OP_R), 1'b1, 1'b0);
    step(enc(7'd0, 5'd3, 5'd3, 5'd4, OP_R), 1'b1, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    n_tests++;
    if (fwd_a !== 2'b10 || fwd_b !== 2'b10 || obs !== exp_v) begin
      n_fail++; $display("FAIL fwd_mem got=%b%b want 1010", fwd_a, fwd_b);
    end
    drain();
    step(enc(7'd0, 5'd2, 5'd1, 5'd3, OP_R), 1'b1, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    step(enc(7'd0, 5'd3, 5'd3, 5'd4, OP_R), 1'b1, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    n_tests++;
    if (fwd_a !== 2'b01 || fwd_b !== 2'b01 || obs !== exp_v) begin
      n_fail++; $display("FAIL fwd_wb got=%b%b want 0101", fwd_a, fwd_b);
    end
    drain();
    step(enc(7'd0, 5'd2, 5'd1, 5'd0, OP_R), 1'b1, 1'b0);
    step(enc(7'd0, 5'd0, 5'd0, 5'd4, OP_R), 1'b1, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    n_tests++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00 || obs !== exp_v) begin
      n_fail++; $display("FAIL fwd_x0 got=%b%b want 0000", fwd_a, fwd_b);
    end
  endtask

  task automatic test_flush_vs_stall();
    drain();
    step(enc(7'd0, 5'd0, 5'd1, 5'd5, OP_LW), 1'b1, 1'b0);
    step(enc(7'd0, 5'd7, 5'd5, 5'd6, OP_R), 1'b1, 1'b1);
    n_tests++;
    if (ifid_flush !== 1'b1 || pc_stall !== 1'b0 || ifid_stall !== 1'b0 || obs !== exp_v) begin
      n_fail++; $display("FAIL flush_prio got=%h want=%h", obs, exp_v);
    end
    step(32'h0, 1'b0, 1'b0);
    n_tests++;
    if (ex_regwrite !== 1'b0 || ex_rd !== 5'd0 || obs !== exp_v) begin
      n_fail++; $display("FAIL flush_bubble got=%h want=%h", obs, exp_v);
    end
  endtask

  task automatic test_decode();
    drain();
    step(enc(7'h12, 5'd3, 5'd2, 5'd7, OP_AUIPC), 1'b1, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    n_tests++;
    if (ex_alusrc !== 1'b1 || ex_regwrite !== 1'b1 || ex_aluop !== 2'b00 || obs !== exp_v) begin
      n_fail++; $display("FAIL dec_auipc got=%h want=%h", obs, exp_v);
    end
    step(enc(7'd0, 5'd3, 5'd2, 5'd7, 7'b1111111), 1'b1, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    n_tests++;
    if (ex_illegal !== 1'b1 || obs !== exp_v ||
        {ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch,
         ex_jal, ex_jalr, ex_aluop} !== 10'b0) begin
      n_fail++; $display("FAIL dec_illegal got=%h want=%h", obs, exp_v);
    end
    step(enc(7'd0, 5'd0, 5'd1, 5'd1, OP_JALR), 1'b1, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    n_tests++;
    if (ex_jal !== 1'b1 || ex_jalr !== 1'b1 || ex_aluop !== 2'b11 || obs !== exp_v) begin
      n_fail++; $display("FAIL dec_jalr got=%h want=%h", obs, exp_v);
    end
  endtask

`ifdef CTRL_MULDIV_EN
  task automatic test_muldiv();
    int nstall;
    logic held;
    drain();
    nstall = 0; held = 1'b1;
    step(enc(7'b0000001, 5'd3, 5'd2, 5'd1, OP_R), 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step(enc(7'd0, 5'd6, 5'd5, 5'd4, OP_R), 1'b1, 1'b0);
      if (pc_stall === 1'b1) nstall++;
      if (ex_rd !== 5'd1 || ex_m !== 1'b1 || mem_regwrite !== 1'b0) held = 1'b0;
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL mul_cyc%0d got=%h want=%h", i, obs, exp_v);
      end
    end
    n_tests++;
    if (nstall != MUL_LAT - 1 || held !== 1'b1) begin
      n_fail++; $display("FAIL mul_stall stalls=%0d held=%b want %0d/1", nstall, held, MUL_LAT - 1);
    end
    step(32'h0, 1'b0, 1'b0);
    n_tests++;
    if (mem_rd !== 5'd1 || mem_regwrite !== 1'b1 || ex_rd !== 5'd4 || obs !== exp_v) begin
      n_fail++; $display("FAIL mul_to_mem mem_rd=%0d ex_rd=%0d want 1/4", mem_rd, ex_rd);
    end
  endtask
`endif

  function automatic logic [31:0] rand_instr();
    logic [6:0] op, f7;
    logic [4:0] rd, rs1, rs2;
    rd = 5'($urandom_range(0, 3));
    rs1 = 5'($urandom_range(0, 3));
    rs2 = 5'($urandom_range(0, 3));
    f7 = 7'($urandom);
    case ($urandom_range(0, 9))
      0: begin
        op = OP_R;
        f7 = ($urandom_range(0, 2) == 0) ? 7'b0000001 : 7'b0000000;
      end
      1: op = OP_I;
      2: op = OP_LW;
      3: op = OP_LW;
      4: op = OP_SW;
      5: op = OP_BR;
      6: op = OP_LUI;
      7: op = ($urandom_range(0, 1) == 0) ? OP_JAL : OP_JALR;
      8: op = OP_AUIPC;
      default: op = ($urandom_range(0, 1) == 0) ? 7'b1111111 : 7'b0000000;
    endcase
    return {f7, rs2, rs1, 3'($urandom), rd, op};
  endfunction

  task automatic test_random();
    logic [31:0] cur;
    logic curv, bt;
    cur = 32'h0; curv = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (exp_stall) begin
        cur = cur;
      end else if (exp_flush) begin
        cur = 32'h0; curv = 1'b0;
      end else begin
        cur = rand_instr(); curv = ($urandom_range(0, 7) != 0);
      end
      bt = ($urandom_range(0, 9) == 0);
      step(cur, curv, bt);
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL random[%0d] got=%h want=%h", i, obs, exp_v);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_async_reset();
    test_load_use();
    test_forwarding();
    test_flush_vs_stall();
    test_decode();
`ifdef CTRL_MULDIV_EN
    test_muldiv();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
